// File: rtl/decim_pkg.sv
// Shared constants, width helper and FIFO word type for the decimation window.
package decim_pkg;

    localparam int DEFAULT_DECIM_RATIO = 256;
    localparam int DEFAULT_FIFO_DEPTH  = 4;
    localparam int DEFAULT_OUT_WIDTH   = 16;
    localparam int DEFAULT_SEQ_WIDTH   = 8;

    // Bits needed to hold a window count of 0..ratio inclusive.
    function automatic int count_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    typedef struct packed {
        logic [DEFAULT_OUT_WIDTH-1:0] count;
        logic [DEFAULT_SEQ_WIDTH-1:0] seq;
    } sample_t;

endpackage

// File: rtl/decimation_window_if.sv
// Valid/ready sample channel from the decimation window to the readout stage.
interface decimation_window_if #(
    parameter int OUT_WIDTH = 16,
    parameter int SEQ_WIDTH = 8
) ();

    logic [OUT_WIDTH-1:0] sample_data;
    logic [SEQ_WIDTH-1:0] sample_seq;
    logic                 sample_valid;
    logic                 sample_ready;

    modport master (
        output sample_data,
        output sample_seq,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_seq,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/decim_sample_fifo.sv
// Synchronous FIFO with a flop-based head; pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate counter.
module decim_sample_fifo
    import decim_pkg::*;
#(
    parameter int  DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter type word_t = sample_t
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  word_t push_data,
    input  logic  pop,
    output word_t head,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    word_t       mem_q [DEPTH];
    word_t       mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/decimation_window.sv
// Counts ones in the registered ADC stream over windows of DECIM_RATIO enabled
// cycles and queues one sequence-tagged sample per window for readout.
module decimation_window
    import decim_pkg::*;
#(
    parameter int DECIM_RATIO = DEFAULT_DECIM_RATIO,
    parameter int OUT_WIDTH   = DEFAULT_OUT_WIDTH,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int SEQ_WIDTH   = DEFAULT_SEQ_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           bit_in,
    decimation_window_if.master            out_if,
    output logic                           overrun,
    output logic [$clog2(DECIM_RATIO)-1:0] window_pos
);

    localparam int               POS_W    = $clog2(DECIM_RATIO);
    localparam int               CNT_W    = count_width(DECIM_RATIO);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(DECIM_RATIO - 1);

    typedef struct packed {
        logic [OUT_WIDTH-1:0] count;
        logic [SEQ_WIDTH-1:0] seq;
    } word_t;

    logic [POS_W-1:0]     pos_q, pos_d;
    logic [CNT_W-1:0]     acc_q, acc_d, acc_sum;
    logic [SEQ_WIDTH-1:0] seq_q, seq_d;
    logic                 overrun_q, overrun_d;
    logic                 push, pop, fifo_full, fifo_empty;
    word_t                push_word, head_word;

    assign pop = !fifo_empty && out_if.sample_ready;

    // The window's final bit is folded into the pushed value rather than the
    // accumulator, so the next window starts on the very next enabled cycle.
    always_comb begin
        acc_d     = acc_q;
        pos_d     = pos_q;
        seq_d     = seq_q;
        overrun_d = overrun_q;
        push      = 1'b0;
        acc_sum   = acc_q + CNT_W'(bit_in);
        push_word.count = OUT_WIDTH'(acc_sum);
        push_word.seq   = seq_q;
        if (enable) begin
            if (pos_q == LAST_POS) begin
                push  = 1'b1;
                acc_d = '0;
                pos_d = '0;
                seq_d = seq_q + SEQ_WIDTH'(1);
            end else begin
                acc_d = acc_sum;
                pos_d = pos_q + POS_W'(1);
            end
        end
        if (push && fifo_full && !pop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            pos_q     <= '0;
            seq_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            pos_q     <= pos_d;
            seq_q     <= seq_d;
            overrun_q <= overrun_d;
        end
    end

    decim_sample_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .word_t (word_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_if.sample_data  = head_word.count;
    assign out_if.sample_seq   = head_word.seq;
    assign out_if.sample_valid = !fifo_empty;
    assign overrun             = overrun_q;
    assign window_pos          = pos_q;

endmodule

// File: tb/tb_decimation_window.sv
// Directed bench for decimation_window with a queue-based reference model
// and hand-computed expectations on the samples the consumer receives.
module tb_decimation_window;

    localparam int RATIO = 8;
    localparam int DEPTH = 4;
    localparam int OW    = 16;
    localparam int SW    = 8;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       bit_in;
    logic       overrun;
    logic [2:0] window_pos;

    decimation_window_if #(.OUT_WIDTH(OW), .SEQ_WIDTH(SW)) out_if ();

    decimation_window #(
        .DECIM_RATIO (RATIO),
        .OUT_WIDTH   (OW),
        .FIFO_DEPTH  (DEPTH),
        .SEQ_WIDTH   (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bit_in     (bit_in),
        .out_if     (out_if),
        .overrun    (overrun),
        .window_pos (window_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    bit checking = 1'b0;

    // Reference model: windows of RATIO enabled bits, a bounded queue of samples.
    int m_pos, m_ones, m_seq;
    bit m_overrun;
    int q_data[$];
    int q_seq[$];
    bit m_pop;

    // Samples the consumer actually took, recorded mid-cycle.
    int log_data[$];
    int log_seq[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit b, input bit rdy);
        enable              = en;
        bit_in              = b;
        out_if.sample_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic applyWindow(input logic [7:0] pat, input bit rdy);
        for (int i = 7; i >= 0; i--) applyStimulus(1'b1, pat[i], rdy);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checking = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        log_data.delete();
        log_seq.delete();
    endtask

    task automatic checkLogEntry(input int idx, input int d, input int s);
        if (idx < log_data.size()) begin
            checkOutput($sformatf("log[%0d].data", idx), log_data[idx], d);
            checkOutput($sformatf("log[%0d].seq", idx), log_seq[idx], s);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL log[%0d]: got no sample, expected data %0d seq %0d", idx, d, s);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_pos = 0;
            m_ones = 0;
            m_seq = 0;
            m_overrun = 1'b0;
            q_data.delete();
            q_seq.delete();
        end else begin
            m_pop = (q_data.size() > 0) && out_if.sample_ready;
            if (m_pop) begin
                void'(q_data.pop_front());
                void'(q_seq.pop_front());
            end
            if (enable) begin
                m_ones += int'(bit_in);
                m_pos++;
                if (m_pos == RATIO) begin
                    if (q_data.size() < DEPTH) begin
                        q_data.push_back(m_ones);
                        q_seq.push_back(m_seq);
                    end else begin
                        m_overrun = 1'b1;
                    end
                    m_seq = (m_seq + 1) % (1 << SW);
                    m_ones = 0;
                    m_pos = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("valid", int'(out_if.sample_valid), int'(q_data.size() > 0));
            checkOutput("overrun", int'(overrun), int'(m_overrun));
            checkOutput("window_pos", int'(window_pos), m_pos);
            if (out_if.sample_valid && q_data.size() > 0) begin
                checkOutput("head.data", int'(out_if.sample_data), q_data[0]);
                checkOutput("head.seq", int'(out_if.sample_seq), q_seq[0]);
            end
            if (out_if.sample_valid && out_if.sample_ready) begin
                log_data.push_back(int'(out_if.sample_data));
                log_seq.push_back(int'(out_if.sample_seq));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset               = 1'b1;
        enable              = 1'b0;
        bit_in              = 1'b0;
        out_if.sample_ready = 1'b0;

        // Reset state
        applyReset();
        checkOutput("rst.valid", int'(out_if.sample_valid), 0);
        checkOutput("rst.data", int'(out_if.sample_data), 0);
        checkOutput("rst.seq", int'(out_if.sample_seq), 0);
        checkOutput("rst.overrun", int'(overrun), 0);
        checkOutput("rst.pos", int'(window_pos), 0);

        // All-ones window: one sample of exactly RATIO, valid for a single cycle
        applyWindow(8'b1111_1111, 1'b1);
        checkOutput("t1.valid", int'(out_if.sample_valid), 1);
        checkOutput("t1.data", int'(out_if.sample_data), 8);
        checkOutput("t1.seq", int'(out_if.sample_seq), 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t1.valid_drop", int'(out_if.sample_valid), 0);
        checkOutput("t1.log_size", log_data.size(), 1);

        // Mixed pattern over three windows, then an all-zero window
        applyReset();
        for (int w = 0; w < 3; w++) applyWindow(8'b1011_0001, 1'b1);
        applyWindow(8'b0000_0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkLogEntry(0, 4, 0);
        checkLogEntry(1, 4, 1);
        checkLogEntry(2, 4, 2);
        checkLogEntry(3, 0, 3);

        // Enable stall mid-window: disabled ones must not be counted
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t3.pos_stall", int'(window_pos), 3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t3.pos_hold", int'(window_pos), 3);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkLogEntry(0, 6, 0);

        // Consumer stalled for six windows: two dropped, tag gap after draining
        applyReset();
        for (int w = 0; w < 6; w++) applyWindow(8'b1111_1111, 1'b0);
        checkOutput("t4.overrun", int'(overrun), 1);
        checkOutput("t4.head_seq", int'(out_if.sample_seq), 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t4.drained", int'(out_if.sample_valid), 0);
        applyWindow(8'b1111_1111, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) checkLogEntry(i, 8, i);
        checkLogEntry(4, 8, 6);
        checkOutput("t4.overrun_sticky", int'(overrun), 1);

        // Full FIFO with pop coinciding with push: nothing is lost
        applyReset();
        for (int w = 0; w < 4; w++) applyWindow(8'b1111_1111, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5.overrun", int'(overrun), 0);
        checkOutput("t5.head_seq", int'(out_if.sample_seq), 1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t5.log_size", log_data.size(), 5);
        for (int i = 0; i < 5; i++) checkLogEntry(i, 8, i);

        // Reset mid-window with buffered samples discards everything
        applyReset();
        for (int w = 0; w < 2; w++) applyWindow(8'b1111_1111, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t6.pos_before", int'(window_pos), 5);
        checkOutput("t6.valid_before", int'(out_if.sample_valid), 1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("t6.valid_after", int'(out_if.sample_valid), 0);
        checkOutput("t6.overrun_after", int'(overrun), 0);
        checkOutput("t6.pos_after", int'(window_pos), 0);
        log_data.delete();
        log_seq.delete();
        applyWindow(8'b1101_0011, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkLogEntry(0, 5, 0);
        checkOutput("t6.log_size", log_data.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
